// File: rtl/rs_bm_ctrl.sv
// Sequencing controller around the combinational BM error-locator datapath;
// optional zero-syndrome bypass under RS_BM_CTRL_ZERO_BYPASS_EN.
package gf_pkg;
    localparam int SYMB_WIDTH = 8;
    localparam int T_VAL      = 2;
    localparam int ROOTS_NUM  = 2 * T_VAL;
    localparam int LEN_WIDTH  = 4;

    typedef logic [T_VAL:0][SYMB_WIDTH-1:0]     poly_t_t;
    typedef logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] synd_t;
endpackage

module rs_bm_ctrl
    import gf_pkg::*;
#(
    parameter int BM_LATENCY = 0
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  synd_t                s_syndrome,
    input  logic                 s_syndrome_vld,
    output logic                 s_syndrome_rdy,
    output synd_t                bm_syndrome,
    output logic                 bm_syndrome_vld,
    input  poly_t_t              bm_error_locator,
    output poly_t_t              m_error_locator,
    output logic [LEN_WIDTH-1:0] m_err_num,
    output logic                 m_no_error,
    output logic                 m_fail,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic                 busy
);
    localparam int CW = (BM_LATENCY > 0) ? $clog2(BM_LATENCY + 1) : 1;
    localparam poly_t_t POLY_ONE = poly_t_t'(1);

`ifdef RS_BM_CTRL_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    synd_t                bm_syndrome_q;
    logic                 bm_syndrome_vld_q;
    poly_t_t              m_error_locator_q;
    logic [LEN_WIDTH-1:0] m_err_num_q;
    logic                 m_no_error_q;
    logic                 m_fail_q;
    logic                 m_vld_q;

    logic                 accept;
    logic                 handoff;
    logic [LEN_WIDTH-1:0] err_num_d;
    logic                 no_error_d;
    logic                 fail_d;

    // DONE passes m_rdy through so a new vector can enter on the handoff cycle.
    assign s_syndrome_rdy = !areset && ((state_q == IDLE) || ((state_q == DONE) && m_rdy));
    assign accept         = s_syndrome_vld && s_syndrome_rdy;
    assign handoff        = m_vld_q && m_rdy;

    always_comb begin
        err_num_d = '0;
        for (int i = 1; i <= T_VAL; i++) begin
            if (|bm_error_locator[i]) begin
                err_num_d = LEN_WIDTH'(i);
            end
        end
        no_error_d = ~|bm_syndrome_q;
        fail_d     = !no_error_d && (err_num_d == '0);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            bm_syndrome_q     <= '0;
            bm_syndrome_vld_q <= 1'b0;
            m_error_locator_q <= '0;
            m_err_num_q       <= '0;
            m_no_error_q      <= 1'b0;
            m_fail_q          <= 1'b0;
            m_vld_q           <= 1'b0;
        end else begin
            case (state_q)
                CALC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        m_error_locator_q <= bm_error_locator;
                        m_err_num_q       <= err_num_d;
                        m_no_error_q      <= no_error_d;
                        m_fail_q          <= fail_d;
                        m_vld_q           <= 1'b1;
                        bm_syndrome_vld_q <= 1'b0;
                        state_q           <= DONE;
                    end
                end
                DONE: begin
                    if (handoff) begin
                        m_vld_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase

            // Accept only happens in IDLE or on a DONE handoff, so it overrides the above.
            if (accept) begin
                bm_syndrome_q <= s_syndrome;
                cnt_q         <= CW'(BM_LATENCY);
                if (ZERO_BYPASS && (s_syndrome == '0)) begin
                    m_error_locator_q <= POLY_ONE;
                    m_err_num_q       <= '0;
                    m_no_error_q      <= 1'b1;
                    m_fail_q          <= 1'b0;
                    m_vld_q           <= 1'b1;
                    bm_syndrome_vld_q <= 1'b0;
                    state_q           <= DONE;
                end else begin
                    bm_syndrome_vld_q <= 1'b1;
                    state_q           <= CALC;
                end
            end
        end
    end

    assign bm_syndrome     = bm_syndrome_q;
    assign bm_syndrome_vld = bm_syndrome_vld_q;
    assign m_error_locator = m_error_locator_q;
    assign m_err_num       = m_err_num_q;
    assign m_no_error      = m_no_error_q;
    assign m_fail          = m_fail_q;
    assign m_vld           = m_vld_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_rs_bm_ctrl.sv
// Bench for rs_bm_ctrl: BM_LATENCY=0 and BM_LATENCY=3 instances, scoreboard checking.
module tb_rs_bm_ctrl;
    import gf_pkg::*;

    typedef struct packed {
        poly_t_t              loc;
        logic [LEN_WIDTH-1:0] num;
        logic                 noerr;
        logic                 fail;
    } exp_t;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic areset;

    synd_t                s_syn0, bm_syn0, s_syn3, bm_syn3;
    logic                 s_vld0, s_rdy0, bm_vld0, s_vld3, s_rdy3, bm_vld3;
    poly_t_t              bm_loc0, m_loc0, bm_loc3, m_loc3;
    logic [LEN_WIDTH-1:0] m_num0, m_num3;
    logic                 m_noerr0, m_fail0, m_vld0, m_rdy0, busy0;
    logic                 m_noerr3, m_fail3, m_vld3, m_rdy3, busy3;
    logic                 corrupt3;

    exp_t q0[$];
    exp_t q3[$];
    int   passed = 0;
    int   total  = 0;

`ifdef RS_BM_CTRL_ZERO_BYPASS_EN
    localparam int  ZERO_LAT = 1;
    localparam bit  ZERO_BMV = 1'b0;
`else
    localparam int  ZERO_LAT = 2;
    localparam bit  ZERO_BMV = 1'b1;
`endif

    function automatic poly_t_t mkpoly(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        poly_t_t p;
        p[0] = c0;
        p[1] = c1;
        p[2] = c2;
        return p;
    endfunction

    // Stand-in for the BM datapath: fixed answers for the vectors used below.
    // [5,0,0,0] deliberately yields locator 1 to provoke the failure flag.
    function automatic poly_t_t bm_model(input synd_t s);
        poly_t_t p;
        p = mkpoly(8'd1, 8'd0, 8'd0);
        case (s)
            {8'd1, 8'd1, 8'd1, 8'd1}: p = mkpoly(8'd1, 8'd1, 8'd0);
            {8'd0, 8'd0, 8'd0, 8'd3}: p = mkpoly(8'd1, 8'h04, 8'd0);
            {8'd0, 8'd0, 8'd0, 8'd7}: p = mkpoly(8'd1, 8'd0, 8'h12);
            default: ;
        endcase
        return p;
    endfunction

    assign bm_loc0 = bm_model(bm_syn0);
    assign bm_loc3 = corrupt3 ? mkpoly(8'hA5, 8'h5A, 8'h33) : bm_model(bm_syn3);

    rs_bm_ctrl #(.BM_LATENCY(0)) u_dut0 (
        .aclk(aclk), .areset(areset),
        .s_syndrome(s_syn0), .s_syndrome_vld(s_vld0), .s_syndrome_rdy(s_rdy0),
        .bm_syndrome(bm_syn0), .bm_syndrome_vld(bm_vld0), .bm_error_locator(bm_loc0),
        .m_error_locator(m_loc0), .m_err_num(m_num0), .m_no_error(m_noerr0),
        .m_fail(m_fail0), .m_vld(m_vld0), .m_rdy(m_rdy0), .busy(busy0)
    );

    rs_bm_ctrl #(.BM_LATENCY(3)) u_dut3 (
        .aclk(aclk), .areset(areset),
        .s_syndrome(s_syn3), .s_syndrome_vld(s_vld3), .s_syndrome_rdy(s_rdy3),
        .bm_syndrome(bm_syn3), .bm_syndrome_vld(bm_vld3), .bm_error_locator(bm_loc3),
        .m_error_locator(m_loc3), .m_err_num(m_num3), .m_no_error(m_noerr3),
        .m_fail(m_fail3), .m_vld(m_vld3), .m_rdy(m_rdy3), .busy(busy3)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    logic        prev_hold = 1'b0;
    logic [63:0] prev_out;

    always @(negedge aclk) begin : mon0
        exp_t e;
        if (areset) begin
            prev_hold = 1'b0;
        end else begin
            if (bm_vld0) check("rdy_low_in_calc", s_rdy0, 1'b0);
            if (prev_hold) begin
                check("hold_vld", m_vld0, 1'b1);
                check("hold_stable", {m_loc0, m_num0, m_noerr0, m_fail0}, prev_out);
            end
            if (m_vld0 && !m_rdy0) check("hold_rdy_low", s_rdy0, 1'b0);
            if (m_vld0 && m_rdy0) begin
                check("result_expected0", (q0.size() != 0), 1'b1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    check("locator0", m_loc0, e.loc);
                    check("err_num0", m_num0, e.num);
                    check("no_error0", m_noerr0, e.noerr);
                    check("fail0", m_fail0, e.fail);
                end
            end
            prev_hold = m_vld0 && !m_rdy0;
            prev_out  = {34'd0, m_loc0, m_num0, m_noerr0, m_fail0};
        end
    end

    always @(negedge aclk) begin : mon3
        exp_t e;
        if (!areset && m_vld3 && m_rdy3) begin
            check("result_expected3", (q3.size() != 0), 1'b1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                check("locator3", m_loc3, e.loc);
                check("err_num3", m_num3, e.num);
                check("no_error3", m_noerr3, e.noerr);
                check("fail3", m_fail3, e.fail);
            end
        end
    end

    // Call at posedge+1. Returns at the negedge where m_vld0 is first seen.
    task automatic send0(input synd_t s, input exp_t e, input int lat, input logic raise_rdy,
                         output int waits, output logic bmv1);
        int n;
        if (raise_rdy) m_rdy0 = 1'b1;
        s_syn0 = s;
        s_vld0 = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_rdy0 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        waits = n;
        check("accept0", s_rdy0, 1'b1);
        q0.push_back(e);
        @(posedge aclk);
        #1 s_vld0 = 1'b0;
        n = 1;
        @(negedge aclk);
        bmv1 = bm_vld0;
        while (!m_vld0 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("latency0", n, lat);
    endtask

    initial begin
        int   w;
        logic b;
        int   hi, first;
        areset = 1'b1;
        s_syn0 = '0; s_vld0 = 1'b0; m_rdy0 = 1'b1;
        s_syn3 = '0; s_vld3 = 1'b0; m_rdy3 = 1'b1;
        corrupt3 = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        check("rst_m_vld", m_vld0, 1'b0);
        check("rst_rdy", s_rdy0, 1'b0);
        check("rst_bm_vld", bm_vld0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_outputs", {m_loc0, m_num0, m_noerr0, m_fail0}, 64'd0);
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("idle_rdy", s_rdy0, 1'b1);

        // Single error
        @(posedge aclk); #1;
        send0({8'd1, 8'd1, 8'd1, 8'd1}, '{mkpoly(8'd1, 8'd1, 8'd0), 4'd1, 1'b0, 1'b0}, 2, 1'b0, w, b);
        check("single_bmv_cycle1", b, 1'b1);

        // Zero syndrome
        @(posedge aclk); #1;
        send0('0, '{mkpoly(8'd1, 8'd0, 8'd0), 4'd0, 1'b1, 1'b0}, ZERO_LAT, 1'b0, w, b);
        check("zero_bmv_cycle1", b, ZERO_BMV);

        // Two-error locator with a zero middle coefficient
        @(posedge aclk); #1;
        send0({8'd0, 8'd0, 8'd0, 8'd7}, '{mkpoly(8'd1, 8'd0, 8'h12), 4'd2, 1'b0, 1'b0}, 2, 1'b0, w, b);

        // Uncorrectable: nonzero syndrome, degree-0 locator
        @(posedge aclk); #1;
        send0({8'd0, 8'd0, 8'd0, 8'd5}, '{mkpoly(8'd1, 8'd0, 8'd0), 4'd0, 1'b0, 1'b1}, 2, 1'b0, w, b);

        // Backpressure, then handoff and accept in the same cycle
        @(posedge aclk); #1;
        m_rdy0 = 1'b0;
        send0({8'd1, 8'd1, 8'd1, 8'd1}, '{mkpoly(8'd1, 8'd1, 8'd0), 4'd1, 1'b0, 1'b0}, 2, 1'b0, w, b);
        repeat (4) @(negedge aclk);
        @(posedge aclk); #1;
        send0({8'd0, 8'd0, 8'd0, 8'd3}, '{mkpoly(8'd1, 8'h04, 8'd0), 4'd1, 1'b0, 1'b0}, 2, 1'b1, w, b);
        check("bp_same_cycle_accept", w, 0);
        check("bp_calc_next_cycle", b, 1'b1);

        // BM_LATENCY=3: capture must use the locator of the last CALC cycle
        @(posedge aclk); #1;
        s_syn3 = {8'd0, 8'd0, 8'd0, 8'd7};
        s_vld3 = 1'b1;
        corrupt3 = 1'b1;
        @(negedge aclk);
        check("accept3", s_rdy3, 1'b1);
        q3.push_back('{mkpoly(8'd1, 8'd0, 8'h12), 4'd2, 1'b0, 1'b0});
        @(posedge aclk); #1;
        s_vld3 = 1'b0;
        hi = 0;
        first = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            corrupt3 = (cyc != 4);
            @(negedge aclk);
            if (bm_vld3) hi++;
            if (m_vld3 && first == 0) first = cyc;
            @(posedge aclk); #1;
        end
        corrupt3 = 1'b0;
        check("lat3_bm_vld_cycles", hi, 4);
        check("lat3_m_vld_cycle", first, 5);

        // Reset during CALC
        s_syn0 = {8'd1, 8'd1, 8'd1, 8'd1};
        s_vld0 = 1'b1;
        @(negedge aclk);
        check("rstcalc_accept", s_rdy0, 1'b1);
        @(posedge aclk); #1;
        s_vld0 = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        check("rstcalc_rdy_in_reset", s_rdy0, 1'b0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("rstcalc_busy", busy0, 1'b0);
        check("rstcalc_rdy", s_rdy0, 1'b1);
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            if (m_vld0) hi++;
            @(negedge aclk);
        end
        check("rstcalc_no_m_vld", hi, 0);

        check("q0_drained", q0.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
